// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver; defining UART_RX_PARITY_EN adds an even-parity bit (8E1).
// data_byte holds the last good byte; data_valid/frame_err/parity_err are one-cycle pulses.
module uart_byte_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t           state_q;
    logic             sync1_q;
    logic             rx_s_q;
    logic             rx_d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [7:0]       data_byte_q;
    logic             data_valid_q;
    logic             frame_err_q;
    logic             busy_q;
    logic             rx_fall;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_q;
    logic             parity_err_q;
`endif

    // Edge detect, counter increment and LSB-first shift candidate
    always_comb begin
        rx_fall = rx_d_q & ~rx_s_q;
        cnt_d   = cnt_q + CNT_ONE;
        shift_d = {rx_s_q, shift_q[7:1]};
    end

    // Synchroniser, receive FSM and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_d_q       <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_byte_q  <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= rx;
            rx_s_q       <= sync1_q;
            rx_d_q       <= rx_s_q;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q <= CNT_ZERO;
                    if (rx_fall) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q     <= CNT_ZERO;
                        bit_idx_q <= 3'd0;
                        // A high line at mid start bit was only a glitch
                        if (!rx_s_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= CNT_ZERO;
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= CNT_ZERO;
                        par_bit_q <= rx_s_q;
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed
                        cnt_q   <= CNT_ZERO;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!rx_s_q) begin
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (even_parity(shift_q) != par_bit_q) begin
                            parity_err_q <= 1'b1;
`endif
                        end else begin
                            data_byte_q  <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= CNT_ZERO;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_byte  = data_byte_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomised self-checking bench for uart_byte_rx (BAUD_DIV = 16); follows UART_RX_PARITY_EN.
// Expected pulses come from a frame-level model: one outcome per transmitted frame.
module tb_uart_byte_rx;
    localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NB = 10;
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        int kind;
        int b;
        int t;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data_byte;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    logic [7:0] prev_byte    = 8'h00;
    logic [7:0] model_byte   = 8'h00;
    ev_t        exp_q[$];
    ev_t        got_q[$];

    uart_byte_rx #(.CLK_FREQ(160), .BAUD_RATE(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_byte  (data_byte),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: collects pulses and enforces exclusivity / byte stability
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid || frame_err || parity_err)
                check("pulse_excl", 32'($countones({data_valid, frame_err, parity_err})), 32'd1);
            if (data_byte != prev_byte)
                check("byte_only_with_valid", 32'(data_valid), 32'd1);
            if (data_valid) got_q.push_back('{0, int'(data_byte), cyc});
            if (frame_err)  got_q.push_back('{1, 0, cyc});
            if (parity_err) got_q.push_back('{2, 0, cyc});
        end
        prev_byte <= data_byte;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BD) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Frame-level reference: the outcome follows from stop bit, then parity, then data
    task automatic expect_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input int t0);
        if (!stop_b) begin
            exp_q.push_back('{1, 0, t0});
        end else if (PAR_EN && (par_b != (^d))) begin
            exp_q.push_back('{2, 0, t0});
        end else begin
            exp_q.push_back('{0, int'(d), t0});
            model_byte = d;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        int t0;
        t0 = cyc;
        expect_frame(d, stop_b, par_b, t0);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
            if (i == 4) check("busy_mid_frame", 32'(busy), 32'd1);
        end
        if (PAR_EN) drive_bit(par_b);
        drive_bit(stop_b);
    endtask

    task automatic flush(input string tag);
        int lat;
        idle(24);
        check({tag, "_num_events"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_ev_kind"}, 32'(got_q[i].kind), 32'(exp_q[i].kind));
            check({tag, "_ev_byte"}, 32'(got_q[i].b), 32'(exp_q[i].b));
            lat = got_q[i].t - exp_q[i].t;
            check({tag, "_ev_latency_in_window"},
                  32'((lat >= (NB - 1) * BD + BD / 2) && (lat <= NB * BD + 4)), 32'd1);
        end
        check({tag, "_data_byte"}, 32'(data_byte), 32'(model_byte));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] hello [5];
        logic       stop_b;
        logic       par_b;
        logic       last_ferr;
        int         gap;

        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;

        repeat (3) @(negedge clk);
        check("rst_data_byte", 32'(data_byte), 32'h00);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        idle(10);

        send_frame(8'h48, 1'b1, ^8'h48);
        flush("single_H");

        for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1, ^hello[i]);
        flush("hello_b2b");

        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        flush("glitch");

        send_frame(8'h41, 1'b0, ^8'h41);
        idle(20);
        send_frame(8'h42, 1'b1, ^8'h42);
        flush("frame_err");

        // Reset in the middle of 0x55's data bits; the rest of the frame is abandoned
        d = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (8) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_data_byte", 32'(data_byte), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        model_byte = 8'h00;
        idle(20);
        flush("mid_reset");
        send_frame(8'h33, 1'b1, ^8'h33);
        flush("after_reset");

        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b1);
            flush("parity_ok");
            send_frame(8'h07, 1'b1, 1'b0);
            flush("parity_bad");
        end

        last_ferr = 1'b0;
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 5; k++) begin
                gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
                // After a low stop bit the line must rise before a new start edge exists
                if (last_ferr && gap < 4) gap = 4;
                if (gap > 0) idle(gap);
                d      = 8'($urandom_range(0, 255));
                stop_b = ($urandom_range(0, 5) != 0);
                par_b  = (^d) ^ ($urandom_range(0, 3) == 0);
                send_frame(d, stop_b, par_b);
                last_ferr = ~stop_b;
            end
            flush("random");
            last_ferr = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
